// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences hold/reset/set/toggle commands onto a shared jk-cell bank.
// Define JK_VERIFY_EN to add the SETTLE read-back compare and the sticky ERR flag.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ,
    input  logic [2*NREQ-1:0]        OP,
    input  logic [WIDTH*NREQ-1:0]    MASK,
    output logic [NREQ-1:0]          ACK,
    output logic [$clog2(NREQ)-1:0]  GNT_ID,
    output logic                     BUSY,
    output logic [WIDTH-1:0]         J,
    output logic [WIDTH-1:0]         K,
    input  logic [WIDTH-1:0]         Q_IN,
    output logic                     ERR
);
    localparam int IDW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             hi_vld;
    logic [IDW-1:0]   hi_id, any_id, pick_id;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_mask;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        any_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                any_id = IDW'(i);
                if (IDW'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_id  = IDW'(i);
                end
            end
        end
        pick_id = hi_vld ? hi_id : any_id;
    end

    always_comb begin
        req_op   = '0;
        req_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == pick_id) begin
                req_op   = OP[2*i +: 2];
                req_mask = MASK[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        mask_d  = mask_q;
        snap_d  = snap_q;
        j_d     = '0;
        k_d     = '0;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    state_d = S_ISSUE;
                    gnt_d   = pick_id;
                    op_d    = req_op;
                    mask_d  = req_mask;
                    snap_d  = Q_IN;
                    // OP bit 1 drives J, bit 0 drives K: 01 reset, 10 set, 11 toggle.
                    j_d     = req_op[1] ? req_mask : '0;
                    k_d     = req_op[0] ? req_mask : '0;
                end
            end
            S_ISSUE: begin
`ifdef JK_VERIFY_EN
                state_d = S_SETTLE;
`else
                state_d = S_DONE;
                ack_d[gnt_q] = 1'b1;
`endif
            end
            S_SETTLE: begin
                state_d = S_DONE;
                ack_d[gnt_q] = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_q    <= '0;
            mask_q  <= '0;
            snap_q  <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            snap_q  <= snap_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

`ifdef JK_VERIFY_EN
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;

    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (state_q == S_ISSUE) begin
            case (op_q)
                2'b01:   exp_d = snap_q & ~mask_q;
                2'b10:   exp_d = snap_q | mask_q;
                2'b11:   exp_d = snap_q ^ mask_q;
                default: exp_d = snap_q;
            endcase
        end
        if (state_q == S_SETTLE && Q_IN != exp_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    // Command fields and snapshot only feed the read-back compare, which is absent here.
    logic unused_latched;
    assign unused_latched = ^{snap_q, op_q, mask_q};
    assign ERR = 1'b0;
`endif

    assign ACK    = ack_q;
    assign GNT_ID = gnt_q;
    assign BUSY   = busy_q;
    assign J      = j_q;
    assign K      = k_q;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter driving a behavioural jk-cell bank.
// Builds with or without JK_VERIFY_EN; latency and ERR expectations follow the macro.
`timescale 1ns/1ps
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
`ifdef JK_VERIFY_EN
    localparam int   LAT    = 4;
    localparam logic VERIFY = 1'b1;
`else
    localparam int   LAT    = 3;
    localparam logic VERIFY = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] mask;
    logic [NREQ-1:0]       ack;
    logic [1:0]            gnt_id;
    logic                  busy;
    logic [WIDTH-1:0]      j, k;
    logic [WIDTH-1:0]      bank_q;
    logic                  err;
    logic                  clr_n;
    int                    total;
    int                    bad;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .OP(op), .MASK(mask),
        .ACK(ack), .GNT_ID(gnt_id), .BUSY(busy), .J(j), .K(k),
        .Q_IN(bank_q), .ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // jk cells with PR held inactive and an active-low asynchronous CLR
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) bank_q <= '0;
        else        bank_q <= (j & ~bank_q) | (~k & bank_q);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int id, input logic [1:0] o, input logic [7:0] m);
        op[2*id +: 2]   = o;
        mask[8*id +: 8] = m;
        req[id]         = 1'b1;
    endtask

    // Waits (bounded) for the next ACK, collecting J/K activity, then checks the transaction.
    task automatic watch(input string tag, input int id, input logic [7:0] ej, input logic [7:0] ek,
                         input logic [7:0] ebank, input int en);
        int         n;
        int         jkc;
        logic [7:0] js, ks;
        n = 0; jkc = 0; js = '0; ks = '0;
        while (n < 16) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if ((j | k) != 0) begin
                js |= j;
                ks |= k;
                jkc++;
            end
            if (ack != 0) break;
        end
        check_eq({tag, ".ack"}, 32'(ack), 32'(1 << id));
        check_eq({tag, ".lat"}, n, en);
        check_eq({tag, ".gnt"}, 32'(gnt_id), id);
        check_eq({tag, ".busy"}, 32'(busy), 1);
        check_eq({tag, ".j"}, 32'(js), 32'(ej));
        check_eq({tag, ".k"}, 32'(ks), 32'(ek));
        check_eq({tag, ".jk_cycles"}, jkc, ((ej | ek) != 0) ? 1 : 0);
        check_eq({tag, ".bank"}, 32'(bank_q), 32'(ebank));
    endtask

    int         rr_id   [5] = '{0, 1, 2, 3, 0};
    logic [7:0] rr_bank [5] = '{8'h0E, 8'h0C, 8'h08, 8'h00, 8'h01};

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; req = '0; op = '0; mask = '0; clr_n = 1'b1;
        #1 rst = 1'b1; clr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.ack", 32'(ack), 0);
        check_eq("rst.busy", 32'(busy), 0);
        check_eq("rst.gnt", 32'(gnt_id), 0);
        check_eq("rst.jk", 32'({j, k}), 0);
        check_eq("rst.err", 32'(err), 0);
        clr_n = 1'b1;
        rst   = 1'b0;

        // single set of the low nibble from an empty bank
        post(0, 2'b10, 8'h0F);
        watch("set0", 0, 8'h0F, 8'h00, 8'h0F, LAT - 1);
        req = '0;
        check_eq("set0.err", 32'(err), 0);
        @(negedge clk);
        check_eq("set0.ack_off", 32'(ack), 0);
        check_eq("set0.idle_busy", 32'(busy), 0);

        // all four toggling their own bit; pointer restarted at 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) post(i, 2'b11, 8'(1 << i));
        for (int n = 0; n < 5; n++) begin
            watch($sformatf("rr%0d", n), rr_id[n], 8'(1 << rr_id[n]), 8'(1 << rr_id[n]),
                  rr_bank[n], (n == 0) ? LAT - 1 : LAT);
        end
        req = '0;
        @(negedge clk);

        // hold opcode moves the pointer to 2 without touching the bank
        post(1, 2'b00, 8'hFF);
        watch("hold1", 1, 8'h00, 8'h00, 8'h01, LAT - 1);
        req = '0;
        @(negedge clk);

        // pointer 2 with requesters 0 and 2 pending: 2 first, then 0
        post(2, 2'b10, 8'h30);
        post(0, 2'b01, 8'h01);
        watch("pri2", 2, 8'h30, 8'h00, 8'h31, LAT - 1);
        req[2] = 1'b0;
        watch("pri0", 0, 8'h00, 8'h01, 8'h30, LAT);
        req = '0;
        @(negedge clk);

        // empty mask still completes
        post(3, 2'b11, 8'h00);
        watch("mask0", 3, 8'h00, 8'h00, 8'h30, LAT - 1);
        req = '0;
        @(negedge clk);

        // reset during ISSUE aborts, then the held request reruns
        post(1, 2'b10, 8'hC0);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort.issue_j", 32'(j), 32'h00C0);
        check_eq("abort.issue_gnt", 32'(gnt_id), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort.jk", 32'({j, k}), 0);
        check_eq("abort.busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("abort.ack", 32'(ack), 0);
        check_eq("abort.bank", 32'(bank_q), 32'h0030);
        rst = 1'b0;
        watch("rerun1", 1, 8'hC0, 8'h00, 8'hF0, LAT - 1);
        req = '0;
        @(negedge clk);

        // bank CLR held active: the set never lands, ERR sticks through a good transaction
        clr_n = 1'b0;
        post(0, 2'b10, 8'hFF);
        watch("clr0", 0, 8'hFF, 8'h00, 8'h00, LAT - 1);
        check_eq("clr0.err", 32'(err), 32'(VERIFY));
        req   = '0;
        clr_n = 1'b1;
        @(negedge clk);
        post(1, 2'b01, 8'hFF);
        watch("good1", 1, 8'h00, 8'hFF, 8'h00, LAT - 1);
        check_eq("good1.err_sticky", 32'(err), 32'(VERIFY));
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("err.cleared", 32'(err), 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
